// File: rtl/avl_sample_fifo_if.sv
// Avalon-MM bus bundle for the sample FIFO responder.
// The master modport is the bus initiator (host or bridge); the slave modport is the FIFO block.
interface avl_sample_fifo_if;
    logic [13:0] address;
    logic [3:0]  byteenable;
    logic        write;
    logic [15:0] writedata;
    logic        read;
    logic        readdatavalid;
    logic [15:0] readdata;
    logic        waitrequest;
    logic        irq;

    modport master (
        output address,
        output byteenable,
        output write,
        output writedata,
        output read,
        input  readdatavalid,
        input  readdata,
        input  waitrequest,
        input  irq
    );

    modport slave (
        input  address,
        input  byteenable,
        input  write,
        input  writedata,
        input  read,
        output readdatavalid,
        output readdata,
        output waitrequest,
        output irq
    );
endinterface

// File: rtl/avl_sample_fifo_slave.sv
// Avalon-MM responder buffering a 16-bit sample stream in a FIFO, drained through a register map.
// Raises a level interrupt on a threshold crossing or on an overflow.
module avl_sample_fifo_slave #(
    parameter int          DEPTH    = 256,
    parameter logic [15:0] ID_VALUE = 16'h5A17
) (
    input  logic                avl_clk_i,
    input  logic                avl_reset_i,
    avl_sample_fifo_if.slave    avl,
    input  logic [15:0]         sample_i,
    input  logic                sample_valid_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] THRESH_0 = LW'(DEPTH / 2);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    localparam logic [13:0] A_ID     = 14'd0;
    localparam logic [13:0] A_CTRL   = 14'd1;
    localparam logic [13:0] A_STATUS = 14'd2;
    localparam logic [13:0] A_LEVEL  = 14'd3;
    localparam logic [13:0] A_THRESH = 14'd4;
    localparam logic [13:0] A_DATA   = 14'd5;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Byte-lane merge: lane 0 covers bits 7:0, lane 1 covers bits 15:8.
    function automatic logic [15:0] merge_bytes(input logic [15:0] old_v,
                                                input logic [15:0] new_v,
                                                input logic [1:0]  be);
        logic [15:0] res;
        res[7:0]  = be[0] ? new_v[7:0]  : old_v[7:0];
        res[15:8] = be[1] ? new_v[15:8] : old_v[15:8];
        return res;
    endfunction

    state_t          state_r;
    state_t          state_next_s;
    logic            waitrequest_r;
    logic [AW-1:0]   clr_cnt_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [LW-1:0]   level_r;
    logic [LW-1:0]   level_next_s;
    logic [LW-1:0]   thresh_r;
    logic            ctrl_en_r;
    logic            ctrl_irq_en_r;
    logic            overflow_r;
    logic            irq_pending_r;
    logic            irq_r;
    logic            rdv_r;
    logic [15:0]     rdata_r;
    logic [15:0]     rd_mux_s;
    logic [15:0]     thresh_merge_s;
    logic [15:0]     mem [DEPTH];

    logic wr_acc_s;
    logic rd_acc_s;
    logic ctrl_wr_s;
    logic go_clear_s;
    logic status_wr_s;
    logic thresh_wr_s;
    logic empty_s;
    logic full_s;
    logic pop_s;
    logic push_req_s;
    logic push_s;
    logic ovf_s;
    logic cross_s;

    // Write wins over a simultaneous read; the read is simply dropped.
    assign wr_acc_s    = avl.write & ~waitrequest_r;
    assign rd_acc_s    = avl.read & ~avl.write & ~waitrequest_r;
    assign ctrl_wr_s   = wr_acc_s & (avl.address == A_CTRL) & avl.byteenable[0];
    assign go_clear_s  = ctrl_wr_s & avl.writedata[1];
    assign status_wr_s = wr_acc_s & (avl.address == A_STATUS) & avl.byteenable[0];
    assign thresh_wr_s = wr_acc_s & (avl.address == A_THRESH);

    assign thresh_merge_s = merge_bytes({{(16-LW){1'b0}}, thresh_r}, avl.writedata,
                                        avl.byteenable[1:0]);

    assign empty_s    = (level_r == LW'(0));
    assign full_s     = (level_r == DEPTH_L);
    assign pop_s      = rd_acc_s & (avl.address == A_DATA) & ~empty_s;
    assign push_req_s = (state_r == ST_RUN) & sample_valid_i & ~go_clear_s;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_s     = push_req_s & (~full_s | pop_s);
    assign ovf_s      = push_req_s & full_s & ~pop_s;

    // Fill level after this cycle's push/pop.
    always_comb begin
        level_next_s = level_r;
        if (push_s && !pop_s) begin
            level_next_s = level_r + LW'(1);
        end else if (pop_s && !push_s) begin
            level_next_s = level_r - LW'(1);
        end else begin
            level_next_s = level_r;
        end
    end

    assign cross_s = (thresh_r != LW'(0)) & (level_r < thresh_r) & (level_next_s >= thresh_r);

    // Next-state logic for the CLEAR/IDLE/RUN controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_cnt_r == LAST_IDX) begin
                    state_next_s = ctrl_en_r ? ST_RUN : ST_IDLE;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (go_clear_s) begin
                    state_next_s = ST_CLEAR;
                end else if (ctrl_wr_s && avl.writedata[0]) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (go_clear_s) begin
                    state_next_s = ST_CLEAR;
                end else if (ctrl_wr_s && !avl.writedata[0]) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_CLEAR;
            end
        endcase
    end

    // Read-data multiplexer, sampled at the accept edge.
    always_comb begin
        rd_mux_s = 16'h0000;
        case (avl.address)
            A_ID:     rd_mux_s = ID_VALUE;
            A_CTRL:   rd_mux_s = {13'd0, ctrl_irq_en_r, 1'b0, ctrl_en_r};
            A_STATUS: rd_mux_s = {12'd0, irq_pending_r, overflow_r, full_s, empty_s};
            A_LEVEL:  rd_mux_s = {{(16-LW){1'b0}}, level_r};
            A_THRESH: rd_mux_s = {{(16-LW){1'b0}}, thresh_r};
            A_DATA: begin
                if (empty_s) begin
                    rd_mux_s = 16'h0000;
                end else begin
                    rd_mux_s = mem[rd_ptr_r];
                end
            end
            default:  rd_mux_s = 16'h0000;
        endcase
    end

    // Controller state, stall output and clear-walk counter.
    always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
        if (!avl_reset_i) begin
            state_r       <= ST_CLEAR;
            waitrequest_r <= 1'b1;
            clr_cnt_r     <= AW'(0);
        end else begin
            state_r       <= state_next_s;
            waitrequest_r <= (state_next_s == ST_CLEAR);
            if (state_r == ST_CLEAR) begin
                clr_cnt_r <= clr_cnt_r + AW'(1);
            end else begin
                clr_cnt_r <= AW'(0);
            end
        end
    end

    // FIFO pointers and fill level; a clear request resets them on the way into CLEAR.
    always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
        if (!avl_reset_i) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= LW'(0);
        end else if (go_clear_s) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= LW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            level_r <= level_next_s;
        end
    end

    // Sample storage; CLEAR zeroes one word per cycle.
    always_ff @(posedge avl_clk_i) begin
        if (state_r == ST_CLEAR) begin
            mem[clr_cnt_r] <= 16'h0000;
        end else if (push_s) begin
            mem[wr_ptr_r] <= sample_i;
        end else begin
            mem[wr_ptr_r] <= mem[wr_ptr_r];
        end
    end

    // Software-visible control and threshold registers.
    always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
        if (!avl_reset_i) begin
            ctrl_en_r     <= 1'b0;
            ctrl_irq_en_r <= 1'b0;
            thresh_r      <= THRESH_0;
        end else begin
            if (ctrl_wr_s) begin
                ctrl_en_r     <= avl.writedata[0];
                ctrl_irq_en_r <= avl.writedata[2];
            end else begin
                ctrl_en_r     <= ctrl_en_r;
                ctrl_irq_en_r <= ctrl_irq_en_r;
            end
            if (thresh_wr_s) begin
                thresh_r <= thresh_merge_s[LW-1:0];
            end else begin
                thresh_r <= thresh_r;
            end
        end
    end

    // Sticky status flags; a new event in the same cycle outranks the W1C.
    always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
        if (!avl_reset_i) begin
            overflow_r    <= 1'b0;
            irq_pending_r <= 1'b0;
            irq_r         <= 1'b0;
        end else begin
            if (go_clear_s) begin
                overflow_r <= 1'b0;
            end else if (ovf_s) begin
                overflow_r <= 1'b1;
            end else if (status_wr_s && avl.writedata[2]) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (ovf_s || cross_s) begin
                irq_pending_r <= 1'b1;
            end else if (status_wr_s && avl.writedata[3]) begin
                irq_pending_r <= 1'b0;
            end else begin
                irq_pending_r <= irq_pending_r;
            end
            irq_r <= irq_pending_r & ctrl_irq_en_r;
        end
    end

    // Read response: one-cycle valid pulse, data forced to zero otherwise.
    always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
        if (!avl_reset_i) begin
            rdv_r   <= 1'b0;
            rdata_r <= 16'h0000;
        end else begin
            rdv_r <= rd_acc_s;
            if (rd_acc_s) begin
                rdata_r <= rd_mux_s;
            end else begin
                rdata_r <= 16'h0000;
            end
        end
    end

    assign avl.readdatavalid = rdv_r;
    assign avl.readdata      = rdata_r;
    assign avl.waitrequest   = waitrequest_r;
    assign avl.irq           = irq_r;

endmodule

// File: tb/tb_avl_sample_fifo_slave.sv
// Scoreboard bench for avl_sample_fifo_slave: reads queue their expected data, a negedge monitor checks responses.
module tb_avl_sample_fifo_slave;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] sample = 16'h0000;
    logic        sample_valid = 1'b0;

    always #5 clk = ~clk;

    avl_sample_fifo_if bus();

    avl_sample_fifo_slave #(.DEPTH(DEPTH), .ID_VALUE(16'h5A17)) dut (
        .avl_clk_i      (clk),
        .avl_reset_i    (rst_n),
        .avl            (bus.slave),
        .sample_i       (sample),
        .sample_valid_i (sample_valid)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q [$];
    string       name_q [$];
    logic [15:0] mon_exp;
    string       mon_name;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    // Response monitor: every readdatavalid pops one expected word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.readdatavalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rdv: got data 0x%04h, expected no response", bus.readdata);
                end else begin
                    mon_exp  = exp_q.pop_front();
                    mon_name = name_q.pop_front();
                    check(mon_name, bus.readdata, mon_exp);
                end
            end else if (bus.readdata !== 16'h0000) begin
                n_cmp++;
                n_err++;
                $display("FAIL idle_readdata: got 0x%04h, expected 0x0000", bus.readdata);
            end
        end
    end

    // All tasks below are entered and left at a falling clock edge.
    task automatic wait_ready(input string name, output int waits);
        waits = 0;
        while (bus.waitrequest !== 1'b0 && waits < 1000) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 1000) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: waitrequest still high after %0d cycles, expected low", name, waits);
        end
    endtask

    task automatic bus_write(input logic [13:0] addr, input logic [15:0] data,
                             input logic [3:0] be, output int waits);
        bus.address    = addr;
        bus.writedata  = data;
        bus.byteenable = be;
        bus.write      = 1'b1;
        wait_ready("write", waits);
        @(posedge clk);
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic wr(input logic [13:0] addr, input logic [15:0] data);
        int w;
        bus_write(addr, data, 4'b0011, w);
    endtask

    task automatic rd(input logic [13:0] addr, input logic [15:0] exp, input string name);
        int w;
        exp_q.push_back(exp);
        name_q.push_back(name);
        bus.address = addr;
        bus.read    = 1'b1;
        wait_ready(name, w);
        @(posedge clk);
        @(negedge clk);
        bus.read = 1'b0;
    endtask

    task automatic push_burst(input logic [15:0] base, input int n);
        sample_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            sample = base + 16'(i);
            @(negedge clk);
        end
        sample_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        bus.address    = 14'd0;
        bus.byteenable = 4'b0000;
        bus.write      = 1'b0;
        bus.writedata  = 16'h0000;
        bus.read       = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        check("rst_waitrequest", {15'd0, bus.waitrequest}, 16'h0001);
        check("rst_rdv", {15'd0, bus.readdatavalid}, 16'h0000);
        check("rst_readdata", bus.readdata, 16'h0000);
        check("rst_irq", {15'd0, bus.irq}, 16'h0000);

        @(negedge clk);
        rst_n = 1'b1;
        waits = 0;
        while (bus.waitrequest === 1'b1 && waits < 1000) begin
            @(negedge clk);
            waits++;
        end
        check("clear_cycles_after_reset", 16'(waits), 16'd256);

        rd(14'd0, 16'h5A17, "id");
        rd(14'd3, 16'h0000, "level_reset");
        rd(14'd2, 16'h0001, "status_reset");
        rd(14'd4, 16'h0080, "thresh_reset");

        // Basic push and drain, including a read of the empty FIFO.
        wr(14'd1, 16'h0001);
        push_burst(16'd10, 1);
        push_burst(16'd20, 1);
        push_burst(16'd30, 1);
        rd(14'd3, 16'h0003, "level_3");
        rd(14'd5, 16'd10, "data_10");
        rd(14'd5, 16'd20, "data_20");
        rd(14'd5, 16'd30, "data_30");
        rd(14'd5, 16'h0000, "data_empty");
        rd(14'd2, 16'h0001, "status_empty");

        // Threshold interrupt.
        wr(14'd1, 16'h0005);
        wr(14'd4, 16'h0004);
        push_burst(16'd1, 4);
        check("irq_same_cycle", {15'd0, bus.irq}, 16'h0000);
        @(negedge clk);
        check("irq_rise", {15'd0, bus.irq}, 16'h0001);
        rd(14'd2, 16'h0008, "status_pending");
        wr(14'd2, 16'h0008);
        check("irq_after_w1c_edge", {15'd0, bus.irq}, 16'h0001);
        @(negedge clk);
        check("irq_drop", {15'd0, bus.irq}, 16'h0000);
        push_burst(16'd5, 1);
        repeat (2) @(negedge clk);
        check("irq_no_retrigger", {15'd0, bus.irq}, 16'h0000);
        rd(14'd3, 16'h0005, "level_5");
        for (int i = 1; i <= 5; i++) rd(14'd5, 16'(i), "data_seq");

        // Fill past capacity.
        push_burst(16'h1000, DEPTH + 1);
        rd(14'd3, 16'h0100, "level_full");
        rd(14'd2, 16'h000E, "status_full_ovf");
        rd(14'd5, 16'h1000, "data_first_after_fill");
        wr(14'd2, 16'h0004);
        rd(14'd2, 16'h0008, "status_ovf_cleared");

        // Push coincident with a pop while full.
        push_burst(16'h2000, 1);
        rd(14'd3, 16'h0100, "level_full_again");
        exp_q.push_back(16'h1001);
        name_q.push_back("data_coincident_pop");
        bus.address  = 14'd5;
        bus.read     = 1'b1;
        sample       = 16'h3000;
        sample_valid = 1'b1;
        wait_ready("coincident", waits);
        @(posedge clk);
        @(negedge clk);
        bus.read     = 1'b0;
        sample_valid = 1'b0;
        rd(14'd3, 16'h0100, "level_after_coincident");
        rd(14'd2, 16'h000A, "status_no_ovf");
        for (int i = 2; i < 256; i++) rd(14'd5, 16'h1000 + 16'(i), "data_drain");
        rd(14'd5, 16'h2000, "data_drain_2000");
        rd(14'd5, 16'h3000, "data_drain_new");
        rd(14'd3, 16'h0000, "level_drained");

        // Clear from RUN with a write held off until the walk completes.
        push_burst(16'h4000, 50);
        rd(14'd3, 16'd50, "level_50");
        wr(14'd1, 16'h0003);
        bus_write(14'd4, 16'h0010, 4'b0011, waits);
        check("clear_cycles_from_run", 16'(waits), 16'd256);
        rd(14'd4, 16'h0010, "thresh_after_clear");
        rd(14'd3, 16'h0000, "level_after_clear");
        rd(14'd1, 16'h0001, "ctrl_after_clear");
        push_burst(16'h5555, 1);
        rd(14'd3, 16'h0001, "level_run_after_clear");
        rd(14'd5, 16'h5555, "data_after_clear");

        // Byte lanes, simultaneous read/write, unmapped addresses.
        bus_write(14'd4, 16'h01FF, 4'b0001, waits);
        rd(14'd4, 16'h00FF, "thresh_be_low");
        bus_write(14'd4, 16'h0100, 4'b0010, waits);
        rd(14'd4, 16'h01FF, "thresh_be_high");
        bus.address   = 14'd4;
        bus.writedata = 16'h0007;
        bus.byteenable = 4'b0011;
        bus.write     = 1'b1;
        bus.read      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.write = 1'b0;
        bus.read  = 1'b0;
        rd(14'd4, 16'h0007, "thresh_write_wins");
        wr(14'd6, 16'hFFFF);
        rd(14'd6, 16'h0000, "addr6");
        rd(14'h3FFF, 16'h0000, "addr_top");

        repeat (4) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL responses_outstanding: got %0d unanswered reads, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
